// File: rtl/mimg_addr_sequencer_pkg.sv
// Shared types for the MIMG address sequencer and its instruction FIFO.
// The MIMG_A16_PACK_EN option is applied in mimg_addr_sequencer, not here.
package mimg_addr_sequencer_pkg;

   localparam int MIMG_NSA_ADDRS = 12;

   typedef struct packed {
      logic [7:0] op;
      logic [2:0] dim;
      logic [3:0] dmask;
      logic [7:0] vdata;
      logic [7:0] vaddr;
      logic [4:0] srsrc;
      logic [4:0] ssamp;
      logic       glc, slc, dlc, r128, tfe, lwe, unrm, a16, d16;
      logic [1:0] nsa;
      logic [MIMG_NSA_ADDRS-1:0][7:0] addr;
   } mimg_inst_t;

   typedef struct packed {
      logic [7:0] op;
      logic [2:0] dim;
      logic [3:0] dmask;
      logic [7:0] vdata;
      logic [4:0] srsrc;
      logic [4:0] ssamp;
      logic       glc, slc, dlc, r128, tfe, lwe, unrm, a16, d16;
      logic [3:0] addr_cnt;
   } mimg_req_t;

   typedef enum logic [2:0] {
      MSEQ_IDLE = 3'b001,
      MSEQ_ADDR = 3'b010,
      MSEQ_DESC = 3'b100
   } mseq_state_t;

   function automatic logic [3:0] mimg_addr_count(input logic [2:0] dim);
      case (dim)
         3'd0:    return 4'd1;
         3'd1:    return 4'd2;
         3'd2:    return 4'd3;
         3'd3:    return 4'd3;
         3'd4:    return 4'd2;
         3'd5:    return 4'd3;
         3'd6:    return 4'd3;
         default: return 4'd4;
      endcase
   endfunction

endpackage

// File: rtl/mimg_addr_sequencer_inst_fifo.sv
// Synchronous FIFO of decoded MIMG instructions; pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module mimg_inst_fifo
   import mimg_addr_sequencer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  mimg_inst_t i_data,
   input  logic       i_pop,
   output mimg_inst_t o_head,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   mimg_inst_t r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // The decoder is stalled on full, so these can only fire on a logic error.
   a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(i_push && o_full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(i_pop && o_empty));

endmodule

// File: rtl/mimg_addr_sequencer.sv
// Buffers decoded MIMG instructions, issues one VGPR address read per operand,
// then one texture descriptor. MIMG_A16_PACK_EN packs two a16 coords per VGPR.
module mimg_addr_sequencer
   import mimg_addr_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_ADDR   = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  mimg_inst_t mimg_inst_in,
   input  logic       mimg_valid_in,
   output logic       dec_stall,
   output logic       vgpr_rd_valid,
   input  logic       vgpr_rd_ready,
   output logic [7:0] vgpr_rd_addr,
   output logic [3:0] vgpr_rd_idx,
   output logic       vgpr_rd_last,
   output logic       tex_req_valid,
   input  logic       tex_req_ready,
   output mimg_req_t  tex_req,
   output logic       busy
);

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   mimg_inst_t  w_head;
   logic [3:0]  w_head_n;
   logic [3:0]  w_next_cnt;

   mseq_state_t r_state;
   mimg_inst_t  r_inst;
   logic [3:0]  r_cnt;
   logic [3:0]  r_n;

   function automatic logic [3:0] addrCount(input mimg_inst_t inst);
      logic [3:0] n;
      logic [4:0] lim;
      n = mimg_addr_count(inst.dim);
`ifdef MIMG_A16_PACK_EN
      if (inst.a16) n = (n + 4'd1) >> 1;
`endif
      lim = 5'd1 + {1'b0, inst.nsa, 2'b00};
      if (lim > 5'(MAX_ADDR)) lim = 5'(MAX_ADDR);
      if ((inst.nsa != 2'd0) && ({1'b0, n} > lim)) n = lim[3:0];
      return n;
   endfunction

   function automatic logic [7:0] operand(input mimg_inst_t inst, input logic [3:0] i);
      if (inst.nsa == 2'd0) return inst.vaddr + {4'd0, i};
      else if (i == 4'd0)   return inst.vaddr;
      else                  return inst.addr[i - 4'd1];
   endfunction

   function automatic mimg_req_t makeReq(input mimg_inst_t inst, input logic [3:0] n);
      mimg_req_t req;
      req = '{op: inst.op, dim: inst.dim, dmask: inst.dmask, vdata: inst.vdata,
              srsrc: inst.srsrc, ssamp: inst.ssamp, glc: inst.glc, slc: inst.slc,
              dlc: inst.dlc, r128: inst.r128, tfe: inst.tfe, lwe: inst.lwe,
              unrm: inst.unrm, a16: inst.a16, d16: inst.d16, addr_cnt: n};
      return req;
   endfunction

   mimg_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (mimg_inst_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A push blocked by this cycle's stall is retaken once the held valid sees it drop.
   assign w_push     = mimg_valid_in && !w_full;
   assign w_pop      = (r_state == MSEQ_DESC) && tex_req_ready;
   assign dec_stall  = w_full;
   assign busy       = !w_empty || (r_state != MSEQ_IDLE);
   assign w_head_n   = addrCount(w_head);
   assign w_next_cnt = r_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= MSEQ_IDLE;
         r_inst        <= '0;
         r_cnt         <= '0;
         r_n           <= '0;
         vgpr_rd_valid <= 1'b0;
         vgpr_rd_addr  <= '0;
         vgpr_rd_idx   <= '0;
         vgpr_rd_last  <= 1'b0;
         tex_req_valid <= 1'b0;
         tex_req       <= '0;
      end else begin
         case (r_state)
            MSEQ_IDLE: begin
               if (!w_empty) begin
                  r_inst        <= w_head;
                  r_n           <= w_head_n;
                  r_cnt         <= '0;
                  vgpr_rd_valid <= 1'b1;
                  vgpr_rd_addr  <= w_head.vaddr;
                  vgpr_rd_idx   <= '0;
                  vgpr_rd_last  <= (w_head_n == 4'd1);
                  r_state       <= MSEQ_ADDR;
               end
            end
            MSEQ_ADDR: begin
               if (vgpr_rd_ready) begin
                  if (vgpr_rd_last) begin
                     vgpr_rd_valid <= 1'b0;
                     vgpr_rd_last  <= 1'b0;
                     tex_req_valid <= 1'b1;
                     tex_req       <= makeReq(r_inst, r_n);
                     r_state       <= MSEQ_DESC;
                  end else begin
                     r_cnt        <= w_next_cnt;
                     vgpr_rd_idx  <= w_next_cnt;
                     vgpr_rd_addr <= operand(r_inst, w_next_cnt);
                     vgpr_rd_last <= (w_next_cnt == r_n - 4'd1);
                  end
               end
            end
            MSEQ_DESC: begin
               if (tex_req_ready) begin
                  tex_req_valid <= 1'b0;
                  r_state       <= MSEQ_IDLE;
               end
            end
            default: r_state <= MSEQ_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mimg_addr_sequencer.md
Name: mimg_addr_sequencer

Overview:
- Sits directly downstream of the MIMG decoder and consumes its decoded mimg_inst_t plus valid pulse.
- Buffers decoded instructions in a small FIFO and back-pressures the decoder through its stall input.
- Walks each instruction's address operands as one VGPR read request per cycle, either contiguous from vaddr or gathered from the NSA list.
- Then issues a single image-request descriptor to the texture/memory pipe.

Parameters:
- FIFO_DEPTH, 2, decoded-instruction FIFO entries (power of two, ≥2).
- MAX_ADDR, 13, max address operands per instruction (vaddr + addr1..addr12).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- mimg_inst_in  in  mimg_inst_t  decoded instruction from the decoder.
- mimg_valid_in  in  1  decoder valid.
- dec_stall  out  1  stall to the decoder; equals FIFO full.
- vgpr_rd_valid  out  1  address-read request valid.
- vgpr_rd_ready  in  1  VGPR file accepts the request.
- vgpr_rd_addr  out  8  VGPR index.
- vgpr_rd_idx  out  4  operand index, 0..MAX_ADDR-1.
- vgpr_rd_last  out  1  final address operand of this instruction.
- tex_req_valid  out  1  descriptor valid.
- tex_req_ready  in  1  texture pipe accepts the descriptor.
- tex_req  out  mimg_req_t  descriptor: op, dim, dmask, vdata, srsrc, ssamp, glc, slc, dlc, r128, tfe, lwe, unrm, a16, d16, addr_cnt[3:0].
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (reset==0 at posedge): FIFO empty; FSM in IDLE; all valid outputs, dec_stall and busy are 0; data outputs are 0.
- Push: on mimg_valid_in && !dec_stall.
  - Because dec_stall freezes the decoder, a held valid is pushed exactly once, after stall drops.
  - Push while full is impossible by construction; the assertion fires if it occurs.
- Simultaneous push and pop when full: the pop frees the slot, but the push is blocked by that cycle's dec_stall and is taken next cycle.
- Address count n:
  - Base count from dim: 0→1, 1→2, 2→3, 3→3, 4→2, 5→3, 6→3, 7→4.
  - With nsa≠0, n is clamped to 1+4*nsa.
- Operand i (i=0..n-1):
  - nsa==0: VGPR vaddr+i, wrapping mod 256.
  - nsa≠0: i==0 → vaddr; i≥1 → addr_i.
- FSM, one-hot {IDLE, ADDR, DESC}:
  - IDLE: if FIFO non-empty, latch the head into a working register, set counter=0, go to ADDR. Latency from push into an empty FIFO to first vgpr_rd_valid is 2 cycles.
  - ADDR: vgpr_rd_valid=1. On handshake the counter increments. vgpr_rd_last=1 when counter==n-1; its handshake moves to DESC.
  - DESC: tex_req_valid=1 with addr_cnt=n. On tex_req_ready: pop the FIFO, go to IDLE. One idle bubble between instructions.
- Valid/ready rules: valid and payload stay stable until ready. Ready may be high before valid. No combinational path from ready to valid.
- Reset mid-operation: in-flight instruction and FIFO contents are discarded; no partial descriptor is emitted.

Optional Feature:
- Macro: MIMG_A16_PACK_EN.
- Defined: when a16==1, two 16-bit coordinates pack per VGPR, so n=ceil(base/2) before the NSA clamp. Example: dim=7, a16=1 gives n=2.
- Undefined: a16 is ignored for counting; it is still forwarded in tex_req.

Decomposition:
- common_pkg gains:
  - mimg_req_t.
  - Dim-to-count constant function mimg_addr_count().
  - FSM state localparams MSEQ_IDLE/ADDR/DESC.
- One sub-module: mimg_inst_fifo, a synchronous FIFO of mimg_inst_t with FIFO_DEPTH entries, full/empty flags and pointer wrap.

Test Plan:
- Reset held 3 cycles with valid high → no push; all outputs 0; busy=0.
- nsa=0, dim=2, vaddr=8'hFE, ready tied high → reads FE, FF, 00 on consecutive cycles, last on 00; then tex_req with addr_cnt=3.
- nsa=1, dim=7, vaddr=10, addr1..4=20,30,40,50 → reads 10, 20, 30, 40; addr_cnt=4.
- Three back-to-back valid pulses with tex_req_ready=0 → dec_stall rises after 2 pushes. Release ready: 3rd instruction pushed exactly once; 3 descriptors issued in order.
- Random vgpr_rd_ready and tex_req_ready toggling → addr and idx stable while valid && !ready; no read dropped or duplicated.
- MIMG_A16_PACK_EN defined, dim=5, a16=1 → n=2. Undefined → n=3.
